ps2_mouse_init_sequencer: RTL and testbench

//  Sequences the PS/2 host transceiver (ps2_rxtx) through the full mouse bring-up script:

---
 rtl/ps2_mouse_init_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_mouse_init_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse bring-up sequencer and movement-packet decoder.
// Drives ps2_rxtx through reset/self-test, sample-rate set and stream enable, with
// ACK/RESEND/timeout handling and bounded retries, then decodes 3-byte packets.
// Optional build macro: PS2_MOUSE_RESYNC_EN drops partial packets after an inter-byte gap.
module ps2_mouse_init_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter logic [7:0]  SAMPLE_RATE    = 8'd100,
  parameter int unsigned PKT_GAP_CYCLES = 2_000_000
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] ps2_rx_data_i,
  input  logic       ps2_rx_done_i,
  input  logic       ps2_tx_done_i,
  output logic       ps2_tx_en_o,
  output logic [7:0] ps2_tx_data_o,
  output logic [8:0] x_velocity_o,
  output logic [8:0] y_velocity_o,
  output logic [2:0] btn_o,
  output logic       packet_valid_o,
  output logic       ready_o,
  output logic       error_o
);

  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GapW   = $clog2(PKT_GAP_CYCLES + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 2);

`ifdef PS2_MOUSE_RESYNC_EN
  localparam bit ResyncEn = 1'b1;
`else
  localparam bit ResyncEn = 1'b0;
`endif

  typedef enum logic [3:0] {
    StSend, StWaitTx, StWaitAck, StWaitBat, StWaitId, StNext, StRetry, StFail,
    StStreamB1, StStreamB2, StStreamB3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [8:0]        x_q, x_d, y_q, y_d;
  logic [2:0]        btn_q, btn_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  // Header fields kept: {ysign, xsign, btn[2:0]}.
  logic [4:0]        hdr_q, hdr_d;
  logic [7:0]        dx_q, dx_d;
  logic              tmo_hit, gap_hit, waiting, in_pkt, retry_full;

  function automatic logic [7:0] script_byte(input logic [1:0] step);
    case (step)
      2'd0:    script_byte = 8'hFF;
      2'd1:    script_byte = 8'hF3;
      2'd2:    script_byte = SAMPLE_RATE;
      default: script_byte = 8'hF4;
    endcase
  endfunction

  // Next-state, script sequencing, packet decode and counter reloads.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    retry_d   = retry_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    x_d       = x_q;
    y_d       = y_q;
    btn_d     = btn_q;
    valid_d   = 1'b0;
    hdr_d     = hdr_q;
    dx_d      = dx_q;
    tmo_hit    = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
    gap_hit    = ResyncEn && (gap_q == GapW'(PKT_GAP_CYCLES - 1));
    retry_full = (retry_q == RetryW'(MAX_RETRIES));

    unique case (state_q)
      StSend: begin
        tx_en_d   = 1'b1;
        tx_data_d = script_byte(step_q);
        state_d   = StWaitTx;
      end
      StWaitTx: if (ps2_tx_done_i) state_d = StWaitAck;
      StWaitAck: begin
        if (ps2_rx_done_i) begin
          if (ps2_rx_data_i == 8'hFA) begin
            state_d = (step_q == 2'd0) ? StWaitBat : StNext;
          end else if (ps2_rx_data_i == 8'hFE) begin
            // Resend request: same byte again, but it still consumes a retry.
            if (retry_full) begin
              state_d = StFail;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = StSend;
            end
          end else begin
            state_d = StRetry;
          end
        end else if (tmo_hit) begin
          state_d = StRetry;
        end
      end
      StWaitBat: begin
        if (ps2_rx_done_i) state_d = (ps2_rx_data_i == 8'hAA) ? StWaitId : StRetry;
        else if (tmo_hit)  state_d = StRetry;
      end
      StWaitId: begin
        if (ps2_rx_done_i) state_d = (ps2_rx_data_i == 8'h00) ? StNext : StRetry;
        else if (tmo_hit)  state_d = StRetry;
      end
      StNext: begin
        if (step_q == 2'd3) begin
          retry_d = '0;
          state_d = StStreamB1;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = StSend;
        end
      end
      StRetry: begin
        if (retry_full) begin
          state_d = StFail;
        end else begin
          retry_d = retry_q + 1'b1;
          step_d  = 2'd0;
          state_d = StSend;
        end
      end
      StFail: state_d = StFail;
      StStreamB1: begin
        // Only a byte with bit3 set can start a packet; anything else is resync noise.
        if (ps2_rx_done_i && ps2_rx_data_i[3]) begin
          hdr_d   = {ps2_rx_data_i[5], ps2_rx_data_i[4], ps2_rx_data_i[2:0]};
          state_d = StStreamB2;
        end
      end
      StStreamB2: begin
        if (ps2_rx_done_i) begin
          dx_d    = ps2_rx_data_i;
          state_d = StStreamB3;
        end else if (gap_hit) begin
          state_d = StStreamB1;
        end
      end
      StStreamB3: begin
        if (ps2_rx_done_i) begin
          x_d     = {hdr_q[3], dx_q};
          y_d     = {hdr_q[4], ps2_rx_data_i};
          btn_d   = hdr_q[2:0];
          valid_d = 1'b1;
          state_d = StStreamB1;
        end else if (gap_hit) begin
          state_d = StStreamB1;
        end
      end
      default: state_d = StSend;
    endcase

    waiting = state_q inside {StWaitAck, StWaitBat, StWaitId};
    in_pkt  = state_q inside {StStreamB2, StStreamB3};
    tmo_d   = (waiting && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
    gap_d   = (ResyncEn && in_pkt && (state_d == state_q)) ? gap_q + 1'b1 : '0;
    ready_d = state_d inside {StStreamB1, StStreamB2, StStreamB3};
    error_d = error_q | (state_d == StFail);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= StSend;
      step_q    <= 2'd0;
      retry_q   <= '0;
      tmo_q     <= '0;
      gap_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'hFF;
      x_q       <= '0;
      y_q       <= '0;
      btn_q     <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      hdr_q     <= '0;
      dx_q      <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      x_q       <= x_d;
      y_q       <= y_d;
      btn_q     <= btn_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      hdr_q     <= hdr_d;
      dx_q      <= dx_d;
    end
  end

  assign ps2_tx_en_o    = tx_en_q;
  assign ps2_tx_data_o  = tx_data_q;
  assign x_velocity_o   = x_q;
  assign y_velocity_o   = y_q;
  assign btn_o          = btn_q;
  assign packet_valid_o = valid_q;
  assign ready_o        = ready_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Self-checking bench for ps2_mouse_init_sequencer: init script, retries, failure,
// table-driven packets, randomized byte streams against a packet-level model.
`timescale 1ns/1ps
module tb_ps2_mouse_init_sequencer;

  localparam int unsigned Tmo = 1000;
  localparam int unsigned Gap = 200;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_done, tx_done;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [8:0] xv, yv;
  logic [2:0] btn;
  logic       pv, ready, err;

  ps2_mouse_init_sequencer #(
    .TIMEOUT_CYCLES(Tmo),
    .MAX_RETRIES   (3),
    .SAMPLE_RATE   (8'd100),
    .PKT_GAP_CYCLES(Gap)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .ps2_rx_data_i (rx_data),
    .ps2_rx_done_i (rx_done),
    .ps2_tx_done_i (tx_done),
    .ps2_tx_en_o   (tx_en),
    .ps2_tx_data_o (tx_data),
    .x_velocity_o  (xv),
    .y_velocity_o  (yv),
    .btn_o         (btn),
    .packet_valid_o(pv),
    .ready_o       (ready),
    .error_o       (err)
  );

  always #5 clk = ~clk;

  typedef logic [20:0] pkt_t;  // {x[8:0], y[8:0], btn[2:0]}
  typedef pkt_t pktq_t[$];
  typedef struct { logic [7:0] b; int idle; } rxb_t;
  typedef rxb_t rxbq_t[$];
  typedef struct {
    bit lead_en; logic [7:0] lead; logic [7:0] b1, b2, b3;
    logic [8:0] ex, ey; logic [2:0] eb;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    tx_cnt = 0;
  int    cyc    = 0;
  int    last_tx_cyc;
  pkt_t  pkt_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: counts transmit strobes and captures every packet strobe.
  always @(negedge clk) begin
    if (tx_en) tx_cnt <= tx_cnt + 1;
    if (pv) pkt_q.push_back({xv, yv, btn});
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  // Wait for a transmit strobe, check the byte, then complete the handshake.
  task automatic do_tx(input logic [7:0] exp, input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_en) begin
        seen = 1'b1;
        break;
      end
    end
    last_tx_cyc = cyc;
    check({name, " tx_en seen"}, 32'(seen), 32'd1);
    if (seen) check({name, " tx byte"}, 32'(tx_data), 32'(exp));
    @(posedge clk);
    #1;
    tick(3);
    check({name, " tx byte held"}, 32'(tx_data), 32'(exp));
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  task automatic nominal_init(input string tag);
    do_tx(8'hFF, {tag, " FF"}, 50);
    rx_byte(8'hFA);
    rx_byte(8'hAA);
    rx_byte(8'h00);
    do_tx(8'hF3, {tag, " F3"}, 50);
    rx_byte(8'hFA);
    do_tx(8'h64, {tag, " rate"}, 50);
    rx_byte(8'hFA);
    do_tx(8'hF4, {tag, " F4"}, 50);
    rx_byte(8'hFA);
    tick(2);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    rx_data = 8'h00;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic send_stream(input rxbq_t s);
    foreach (s[i]) begin
      tick(s[i].idle);
      rx_byte(s[i].b);
    end
  endtask

  // Packet-level reference: a packet is a bit3 header plus the next two bytes; with resync a
  // long silence before byte 2 or 3 abandons the packet and scanning restarts at that byte.
  function automatic pktq_t model(input rxbq_t s);
    pktq_t out;
    int i = 0;
    int n = s.size();
    while (i < n) begin
      if (!s[i].b[3] || (i + 2 >= n)) begin
        i++;
        continue;
      end
`ifdef PS2_MOUSE_RESYNC_EN
      if (s[i+1].idle >= int'(Gap)) begin
        i = i + 1;
        continue;
      end
      if (s[i+2].idle >= int'(Gap)) begin
        i = i + 2;
        continue;
      end
`endif
      out.push_back({s[i].b[4], s[i+1].b, s[i].b[5], s[i+2].b, s[i].b[2:0]});
      i += 3;
    end
    return out;
  endfunction

  vec_t  vecs[6];
  rxbq_t rs;
  rxb_t  r;
  pktq_t expq;
  int    p0, t0, prev;

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'h19, 8'h05, 8'hFB, 9'h105, 9'h0FB, 3'b001};
    vecs[1] = '{1'b1, 8'h00, 8'h08, 8'h10, 8'h20, 9'h010, 9'h020, 3'b000};
    vecs[2] = '{1'b0, 8'h00, 8'h38, 8'hFF, 8'hFE, 9'h1FF, 9'h1FE, 3'b000};
    vecs[3] = '{1'b0, 8'h00, 8'hCF, 8'h7F, 8'h80, 9'h07F, 9'h080, 3'b111};
    vecs[4] = '{1'b1, 8'h07, 8'h2A, 8'h00, 8'h01, 9'h000, 9'h101, 3'b010};
    vecs[5] = '{1'b1, 8'hF7, 8'h1C, 8'h80, 8'h7F, 9'h180, 9'h07F, 3'b100};

    reset_n = 1'b0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    rx_data = 8'h00;
    tick(3);
    @(negedge clk);
    check("reset tx_en", 32'(tx_en), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'hFF);
    check("reset x", 32'(xv), 32'd0);
    check("reset y", 32'(yv), 32'd0);
    check("reset btn", 32'(btn), 32'd0);
    check("reset valid", 32'(pv), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    check("reset error", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Nominal bring-up.
    t0 = tx_cnt;
    nominal_init("init");
    check("init ready", 32'(ready), 32'd1);
    check("init error", 32'(err), 32'd0);
    check("init tx count", 32'(tx_cnt - t0), 32'd4);

    // Table-driven packets, bytes back-to-back.
    foreach (vecs[k]) begin
      p0 = pkt_q.size();
      if (vecs[k].lead_en) rx_byte(vecs[k].lead);
      rx_byte(vecs[k].b1);
      rx_byte(vecs[k].b2);
      rx_byte(vecs[k].b3);
      @(negedge clk);
      check($sformatf("vec%0d valid pulse", k), 32'(pv), 32'd1);
      check($sformatf("vec%0d x", k), 32'(xv), 32'(vecs[k].ex));
      check($sformatf("vec%0d y", k), 32'(yv), 32'(vecs[k].ey));
      check($sformatf("vec%0d btn", k), 32'(btn), 32'(vecs[k].eb));
      @(negedge clk);
      check($sformatf("vec%0d valid drop", k), 32'(pv), 32'd0);
      @(posedge clk);
      #1;
      tick(3);
      check($sformatf("vec%0d pulse count", k), 32'(pkt_q.size() - p0), 32'd1);
    end
    tick(20);
    check("hold x", 32'(xv), 32'h180);
    check("hold y", 32'(yv), 32'h07F);
    check("hold btn", 32'(btn), 32'd4);

    // Randomized byte stream with short gaps, two pad bytes close any partial packet.
    rs.delete();
    for (int i = 0; i < 60; i++) begin
      r.b    = 8'($urandom);
      r.idle = int'($urandom_range(0, 4));
      rs.push_back(r);
    end
    r.b    = 8'h00;
    r.idle = 0;
    rs.push_back(r);
    rs.push_back(r);
    expq = model(rs);
    p0 = pkt_q.size();
    send_stream(rs);
    tick(3);
    check("rand pkt count", 32'(pkt_q.size() - p0), 32'(expq.size()));
    for (int i = 0; i < expq.size() && (p0 + i) < pkt_q.size(); i++)
      check($sformatf("rand pkt %0d", i), 32'(pkt_q[p0+i]), 32'(expq[i]));

    // Long gap inside a packet.
    rs.delete();
    r.idle = 0;   r.b = 8'h08; rs.push_back(r);
    r.b = 8'h10;  rs.push_back(r);
    r.idle = 300; r.b = 8'h09; rs.push_back(r);
    r.idle = 0;   r.b = 8'h01; rs.push_back(r);
    r.b = 8'h02;  rs.push_back(r);
    expq = model(rs);
    p0 = pkt_q.size();
    send_stream(rs);
    tick(5);
    check("gap pkt count", 32'(pkt_q.size() - p0), 32'(expq.size()));
    if (expq.size() > 0 && pkt_q.size() > p0)
      check("gap pkt", 32'(pkt_q[p0]), 32'(expq[0]));

    // RESEND in reply to F3.
    do_reset();
    t0 = tx_cnt;
    do_tx(8'hFF, "fe FF", 50);
    rx_byte(8'hFA);
    rx_byte(8'hAA);
    rx_byte(8'h00);
    do_tx(8'hF3, "fe F3", 50);
    rx_byte(8'hFE);
    do_tx(8'hF3, "fe F3 resend", 50);
    rx_byte(8'hFA);
    do_tx(8'h64, "fe rate", 50);
    rx_byte(8'hFA);
    do_tx(8'hF4, "fe F4", 50);
    rx_byte(8'hFA);
    tick(2);
    check("fe ready", 32'(ready), 32'd1);
    check("fe error", 32'(err), 32'd0);
    check("fe tx count", 32'(tx_cnt - t0), 32'd5);

    // Silence after every reset command: four attempts, then terminal failure.
    do_reset();
    t0 = tx_cnt;
    prev = 0;
    for (int a = 0; a < 4; a++) begin
      do_tx(8'hFF, $sformatf("silence try%0d", a), 1200);
      if (a > 0)
        check($sformatf("silence spacing %0d", a),
              32'((last_tx_cyc - prev >= 1000) && (last_tx_cyc - prev <= 1030)), 32'd1);
      prev = last_tx_cyc;
    end
    tick(1100);
    check("fail error", 32'(err), 32'd1);
    check("fail ready", 32'(ready), 32'd0);
    check("fail tx count", 32'(tx_cnt - t0), 32'd4);
    rx_byte(8'hFA);
    rx_byte(8'hAA);
    tick(20);
    check("fail stays quiet", 32'(tx_cnt - t0), 32'd4);
    check("fail sticky", 32'(err), 32'd1);

    // Reset clears the failure and restarts the script from the first byte.
    reset_n = 1'b0;
    @(negedge clk);
    check("rst clears error", 32'(err), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'hFF);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_tx(8'hFF, "restart", 50);
    check("restart error", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
